// File: rtl/dram_pkg.sv
// Shared types for the DRAM device model: command encoding, error-bit indices
// and the command-pin decoder.
package dram_pkg;

    typedef enum logic [2:0] {
        NOP,
        ACT,
        PRE,
        RD,
        WR,
        REF,
        ILLEGAL
    } dram_cmd_e;

    localparam int ERR_W       = 6;
    localparam int ILLEGAL_CMD = 0;
    localparam int ACT_OPEN    = 1;
    localparam int TIMING      = 2;
    localparam int ROW_CLOSED  = 3;
    localparam int REF_OPEN    = 4;
    localparam int REF_OVERDUE = 5;

    // DESELECT folds into NOP; any unlisted code with cs_n low is ILLEGAL.
    function automatic dram_cmd_e decode_cmd(input logic cs_n, input logic ras_n,
                                             input logic cas_n, input logic we_n);
        dram_cmd_e cmd;
        if (cs_n) begin
            cmd = NOP;
        end else begin
            case ({ras_n, cas_n, we_n})
                3'b111:  cmd = NOP;
                3'b011:  cmd = ACT;
                3'b010:  cmd = PRE;
                3'b101:  cmd = RD;
                3'b100:  cmd = WR;
                3'b001:  cmd = REF;
                default: cmd = ILLEGAL;
            endcase
        end
        return cmd;
    endfunction

endpackage

// File: rtl/dram_bank_state.sv
// Per-bank tracker: open flag, active row and a shared T_RCD/T_RP down-counter.
// ready is high once the most recent ACTIVATE/PRECHARGE timing has elapsed.
module dram_bank_state #(
    parameter int ROW_WIDTH = 7,
    parameter int T_RCD     = 1,
    parameter int T_RP      = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clk_en,
    input  logic                 act,
    input  logic                 pre,
    input  logic [ROW_WIDTH-1:0] row_in,
    output logic                 open,
    output logic [ROW_WIDTH-1:0] row,
    output logic                 ready
);

    localparam int T_MAX = (T_RCD > T_RP) ? T_RCD : T_RP;
    localparam int CNT_W = (T_MAX > 1) ? $clog2(T_MAX) : 1;
    localparam logic [CNT_W-1:0] RCD_LOAD = (T_RCD > 0) ? CNT_W'(T_RCD - 1) : '0;
    localparam logic [CNT_W-1:0] RP_LOAD  = (T_RP > 0)  ? CNT_W'(T_RP - 1)  : '0;

    logic                 open_q, open_d;
    logic [ROW_WIDTH-1:0] row_q, row_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;

    // The command edge itself counts as the first elapsed cycle, hence T-1.
    always_comb begin
        open_d = open_q;
        row_d  = row_q;
        cnt_d  = cnt_q;
        if (clk_en && cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
        if (act) begin
            open_d = 1'b1;
            row_d  = row_in;
            cnt_d  = RCD_LOAD;
        end else if (pre && open_q) begin
            open_d = 1'b0;
            cnt_d  = RP_LOAD;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            open_q <= 1'b0;
            row_q  <= '0;
            cnt_q  <= '0;
        end else begin
            open_q <= open_d;
            row_q  <= row_d;
            cnt_q  <= cnt_d;
        end
    end

    assign open  = open_q;
    assign row   = row_q;
    assign ready = (cnt_q == '0);

endmodule

// File: rtl/dram_device_model.sv
// Cycle-accurate DRAM responder with protocol checking. Define
// DRAM_MODEL_REFRESH_CHECK_EN to include the refresh-deadline watchdog (err[5]).
module dram_device_model
    import dram_pkg::*;
#(
    parameter int NUMBER_OF_COLUMNS      = 8,
    parameter int NUMBER_OF_ROWS         = 128,
    parameter int NUMBER_OF_BANKS        = 8,
    parameter int DRAM_DATA_WIDTH        = 8,
    parameter int CAS_LATENCY            = 2,
    parameter int T_RCD                  = 1,
    parameter int T_RP                   = 1,
    parameter int T_RFC                  = 2,
    parameter int CYCLES_BETWEEN_REFRESH = 1250,
    localparam int COLUMN_WIDTH    = (NUMBER_OF_COLUMNS > 1) ? $clog2(NUMBER_OF_COLUMNS) : 1,
    localparam int ROW_WIDTH       = (NUMBER_OF_ROWS > 1) ? $clog2(NUMBER_OF_ROWS) : 1,
    localparam int BANK_ID_WIDTH   = (NUMBER_OF_BANKS > 1) ? $clog2(NUMBER_OF_BANKS) : 1,
    localparam int DRAM_ADDR_WIDTH = (ROW_WIDTH > COLUMN_WIDTH) ? ROW_WIDTH : COLUMN_WIDTH
) (
    input  logic                       u_clk,
    input  logic                       u_rst_n,
    input  logic                       dram_clk_en,
    input  logic                       dram_cs_n,
    input  logic                       dram_ras_n,
    input  logic                       dram_cas_n,
    input  logic                       dram_we_n,
    input  logic [DRAM_ADDR_WIDTH-1:0] dram_addr,
    input  logic [BANK_ID_WIDTH-1:0]   dram_bank_id,
    input  logic [DRAM_DATA_WIDTH-1:0] dram_wr_data,
    output logic [DRAM_DATA_WIDTH-1:0] dram_rd_data,
    output logic                       dram_rd_valid,
    output logic [ERR_W-1:0]           err_status,
    output logic                       err_pulse
);

    localparam int IDX_W   = BANK_ID_WIDTH + ROW_WIDTH + COLUMN_WIDTH;
    localparam int RFC_W   = (T_RFC > 1) ? $clog2(T_RFC) : 1;
    localparam logic [RFC_W-1:0] RFC_LOAD = (T_RFC > 0) ? RFC_W'(T_RFC - 1) : '0;

    logic [DRAM_DATA_WIDTH-1:0] mem [0:(1 << IDX_W) - 1];

    logic [NUMBER_OF_BANKS-1:0] bank_open, bank_ready, bank_act, bank_pre;
    logic [ROW_WIDTH-1:0]       bank_row [NUMBER_OF_BANKS];

    dram_cmd_e                  cmd;
    logic                       sel_open, sel_ready, ref_busy;
    logic [ROW_WIDTH-1:0]       sel_row;
    logic [IDX_W-1:0]           mem_idx;
    logic                       act_go, pre_go, rd_go, wr_go, ref_go;
    logic [ERR_W-1:0]           err_set;

    logic [CAS_LATENCY-1:0]                      rd_vld_q, rd_vld_d;
    logic [CAS_LATENCY-1:0][DRAM_DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    logic [RFC_W-1:0]                            ref_cnt_q, ref_cnt_d;
    logic [ERR_W-1:0]                            err_status_q, err_status_d;
    logic                                        err_pulse_q, err_pulse_d;

    for (genvar g = 0; g < NUMBER_OF_BANKS; g++) begin : g_bank
        dram_bank_state #(
            .ROW_WIDTH (ROW_WIDTH),
            .T_RCD     (T_RCD),
            .T_RP      (T_RP)
        ) u_bank (
            .clk    (u_clk),
            .rst_n  (u_rst_n),
            .clk_en (dram_clk_en),
            .act    (bank_act[g]),
            .pre    (bank_pre[g]),
            .row_in (dram_addr[ROW_WIDTH-1:0]),
            .open   (bank_open[g]),
            .row    (bank_row[g]),
            .ready  (bank_ready[g])
        );
    end

    always_comb begin
        cmd       = decode_cmd(dram_cs_n, dram_ras_n, dram_cas_n, dram_we_n);
        sel_open  = bank_open[dram_bank_id];
        sel_ready = bank_ready[dram_bank_id];
        sel_row   = bank_row[dram_bank_id];
        mem_idx   = {dram_bank_id, sel_row, dram_addr[COLUMN_WIDTH-1:0]};
        ref_busy  = (ref_cnt_q != '0);
        err_set   = '0;
        act_go    = 1'b0;
        pre_go    = 1'b0;
        rd_go     = 1'b0;
        wr_go     = 1'b0;
        ref_go    = 1'b0;
        if (dram_clk_en) begin
            if (cmd == ILLEGAL) begin
                err_set[ILLEGAL_CMD] = 1'b1;
            end else if (cmd != NOP) begin
                // Everything but NOP is dropped while a refresh is in progress.
                if (ref_busy) begin
                    err_set[TIMING] = 1'b1;
                end else begin
                    case (cmd)
                        ACT: begin
                            act_go = 1'b1;
                            if (sel_open)       err_set[ACT_OPEN] = 1'b1;
                            else if (!sel_ready) err_set[TIMING]  = 1'b1;
                        end
                        PRE: pre_go = 1'b1;
                        RD, WR: begin
                            if (!sel_open) begin
                                err_set[ROW_CLOSED] = 1'b1;
                            end else begin
                                rd_go = (cmd == RD);
                                wr_go = (cmd == WR);
                                if (!sel_ready) err_set[TIMING] = 1'b1;
                            end
                        end
                        REF: begin
                            ref_go = 1'b1;
                            if (|bank_open)                  err_set[REF_OPEN] = 1'b1;
                            if (|(~bank_open & ~bank_ready)) err_set[TIMING]   = 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
        end
        for (int i = 0; i < NUMBER_OF_BANKS; i++) begin
            bank_act[i] = act_go && (dram_bank_id == BANK_ID_WIDTH'(i));
            bank_pre[i] = pre_go && (dram_bank_id == BANK_ID_WIDTH'(i));
        end
    end

`ifdef DRAM_MODEL_REFRESH_CHECK_EN
    localparam int WD_W = $clog2(CYCLES_BETWEEN_REFRESH + 1);
    localparam logic [WD_W-1:0] WD_RELOAD = WD_W'(CYCLES_BETWEEN_REFRESH);

    logic [WD_W-1:0] wd_q, wd_d;
    logic            wd_expire;

    always_comb begin
        wd_d      = wd_q;
        wd_expire = 1'b0;
        if (dram_clk_en) begin
            if (ref_go) begin
                wd_d = WD_RELOAD;
            end else if (wd_q == '0) begin
                wd_d      = WD_RELOAD;
                wd_expire = 1'b1;
            end else begin
                wd_d = wd_q - WD_W'(1);
            end
        end
    end

    always_ff @(posedge u_clk or negedge u_rst_n) begin
        if (!u_rst_n) wd_q <= WD_RELOAD;
        else          wd_q <= wd_d;
    end
`else
    logic wd_expire;
    assign wd_expire = 1'b0;
`endif

    // Read pipeline: stage 0 captures array data at the READ edge, last stage drives the pins.
    always_comb begin
        rd_vld_d  = rd_vld_q;
        rd_data_d = rd_data_q;
        ref_cnt_d = ref_cnt_q;
        if (dram_clk_en) begin
            rd_vld_d[0]  = rd_go;
            rd_data_d[0] = rd_go ? mem[mem_idx] : '0;
            for (int i = 1; i < CAS_LATENCY; i++) begin
                rd_vld_d[i]  = rd_vld_q[i-1];
                rd_data_d[i] = rd_data_q[i-1];
            end
            if (ref_go)        ref_cnt_d = RFC_LOAD;
            else if (ref_busy) ref_cnt_d = ref_cnt_q - RFC_W'(1);
        end
        err_status_d = err_status_q | err_set | {wd_expire, {(ERR_W-1){1'b0}}};
        err_pulse_d  = (|err_set) | wd_expire;
    end

    always_ff @(posedge u_clk or negedge u_rst_n) begin
        if (!u_rst_n) begin
            rd_vld_q     <= '0;
            rd_data_q    <= '0;
            ref_cnt_q    <= '0;
            err_status_q <= '0;
            err_pulse_q  <= 1'b0;
        end else begin
            rd_vld_q     <= rd_vld_d;
            rd_data_q    <= rd_data_d;
            ref_cnt_q    <= ref_cnt_d;
            err_status_q <= err_status_d;
            err_pulse_q  <= err_pulse_d;
        end
    end

    always_ff @(posedge u_clk) begin
        if (wr_go) mem[mem_idx] <= dram_wr_data;
    end

    assign dram_rd_data  = rd_data_q[CAS_LATENCY-1];
    assign dram_rd_valid = rd_vld_q[CAS_LATENCY-1];
    assign err_status    = err_status_q;
    assign err_pulse     = err_pulse_q;

endmodule

// File: tb/tb_dram_device_model.sv
// Self-checking bench for dram_device_model: directed scenarios plus random
// command traffic scored against a timestamp-based behavioural model.
module tb_dram_device_model;

    localparam int NC = 8, NR = 128, NB = 8, DW = 8;
    localparam int CL = 2, TRCD = 2, TRP = 2, TRFC = 3, CBR = 20;
    localparam int AW = 7, BW = 3;

    localparam logic [3:0] C_DES = 4'b1111, C_NOP = 4'b0111, C_ACT = 4'b0011;
    localparam logic [3:0] C_PRE = 4'b0010, C_RD  = 4'b0101, C_WR  = 4'b0100;
    localparam logic [3:0] C_REF = 4'b0001;

    logic          u_clk = 1'b0;
    logic          u_rst_n = 1'b0;
    logic          dram_clk_en = 1'b0;
    logic          dram_cs_n = 1'b1, dram_ras_n = 1'b1, dram_cas_n = 1'b1, dram_we_n = 1'b1;
    logic [AW-1:0] dram_addr = '0;
    logic [BW-1:0] dram_bank_id = '0;
    logic [DW-1:0] dram_wr_data = '0;
    logic [DW-1:0] dram_rd_data;
    logic          dram_rd_valid;
    logic [5:0]    err_status;
    logic          err_pulse;

    always #5 u_clk = ~u_clk;

    dram_device_model #(
        .NUMBER_OF_COLUMNS      (NC),
        .NUMBER_OF_ROWS         (NR),
        .NUMBER_OF_BANKS        (NB),
        .DRAM_DATA_WIDTH        (DW),
        .CAS_LATENCY            (CL),
        .T_RCD                  (TRCD),
        .T_RP                   (TRP),
        .T_RFC                  (TRFC),
        .CYCLES_BETWEEN_REFRESH (CBR)
    ) dut (
        .u_clk         (u_clk),
        .u_rst_n       (u_rst_n),
        .dram_clk_en   (dram_clk_en),
        .dram_cs_n     (dram_cs_n),
        .dram_ras_n    (dram_ras_n),
        .dram_cas_n    (dram_cas_n),
        .dram_we_n     (dram_we_n),
        .dram_addr     (dram_addr),
        .dram_bank_id  (dram_bank_id),
        .dram_wr_data  (dram_wr_data),
        .dram_rd_data  (dram_rd_data),
        .dram_rd_valid (dram_rd_valid),
        .err_status    (err_status),
        .err_pulse     (err_pulse)
    );

    int total = 0;
    int bad = 0;

    // Model: timing tracked as timestamps in enabled-cycle units.
    logic [DW-1:0] m_mem [0:NB*NR*NC-1];
    bit            m_open [NB];
    int            m_row [NB];
    int            m_act_t [NB];
    int            m_pre_t [NB];
    int            m_ref_t, m_now, m_since;
    logic [5:0]    m_err;
    logic          m_pulse;
    int            q_due [$];
    logic [DW-1:0] q_data [$];
    logic          exp_vld;
    logic [DW-1:0] exp_data;

    function automatic void model_reset();
        m_now   = 1000;
        m_ref_t = 0;
        m_since = 0;
        m_err   = '0;
        m_pulse = 1'b0;
        for (int b = 0; b < NB; b++) begin
            m_open[b]  = 1'b0;
            m_row[b]   = 0;
            m_act_t[b] = 0;
            m_pre_t[b] = 0;
        end
        q_due.delete();
        q_data.delete();
        exp_vld = 1'b0;
    endfunction

    task automatic step(input logic [3:0] code, input int bank, input int addr,
                        input logic [DW-1:0] wd, input bit en);
        logic [5:0] e;
        bit         ref_exec;
        int         idx;
        e        = '0;
        ref_exec = 1'b0;
        {dram_cs_n, dram_ras_n, dram_cas_n, dram_we_n} = code;
        dram_bank_id = BW'(bank);
        dram_addr    = AW'(addr);
        dram_wr_data = wd;
        dram_clk_en  = en;
        if (en) begin
            if (code[3] == 1'b0 && code != C_NOP) begin
                if (!(code inside {C_ACT, C_PRE, C_RD, C_WR, C_REF})) begin
                    e[0] = 1'b1;
                end else if (m_now - m_ref_t < TRFC) begin
                    e[2] = 1'b1;
                end else if (code == C_ACT) begin
                    if (m_open[bank])                    e[1] = 1'b1;
                    else if (m_now - m_pre_t[bank] < TRP) e[2] = 1'b1;
                    m_open[bank]  = 1'b1;
                    m_row[bank]   = addr % NR;
                    m_act_t[bank] = m_now;
                end else if (code == C_PRE) begin
                    if (m_open[bank]) begin
                        m_open[bank]  = 1'b0;
                        m_pre_t[bank] = m_now;
                    end
                end else if (code == C_RD || code == C_WR) begin
                    if (!m_open[bank]) begin
                        e[3] = 1'b1;
                    end else begin
                        if (m_now - m_act_t[bank] < TRCD) e[2] = 1'b1;
                        idx = (bank * NR + m_row[bank]) * NC + addr % NC;
                        if (code == C_WR) begin
                            m_mem[idx] = wd;
                        end else begin
                            q_due.push_back(m_now + CL);
                            q_data.push_back(m_mem[idx]);
                        end
                    end
                end else begin
                    ref_exec = 1'b1;
                    m_ref_t  = m_now;
                    for (int b = 0; b < NB; b++) begin
                        if (m_open[b])                     e[4] = 1'b1;
                        else if (m_now - m_pre_t[b] < TRP) e[2] = 1'b1;
                    end
                end
            end
            if (ref_exec) begin
                m_since = 0;
            end else begin
                m_since++;
                if (m_since == CBR + 1) begin
                    m_since = 0;
`ifdef DRAM_MODEL_REFRESH_CHECK_EN
                    e[5] = 1'b1;
`endif
                end
            end
            m_now++;
        end
        @(posedge u_clk);
        #1;
        m_err   = m_err | e;
        m_pulse = |e;
        while (q_due.size() > 0 && q_due[0] < m_now) begin
            void'(q_due.pop_front());
            void'(q_data.pop_front());
        end
        exp_vld  = (q_due.size() > 0) && (q_due[0] == m_now);
        exp_data = exp_vld ? q_data[0] : '0;
    endtask

    task automatic cmd_nop();                          step(C_NOP, 0, 0, '0, 1'b1); endtask
    task automatic cmd_act(input int b, input int r);  step(C_ACT, b, r, '0, 1'b1); endtask
    task automatic cmd_pre(input int b);               step(C_PRE, b, 0, '0, 1'b1); endtask
    task automatic cmd_rd(input int b, input int c);   step(C_RD,  b, c, '0, 1'b1); endtask
    task automatic cmd_ref();                          step(C_REF, 0, 0, '0, 1'b1); endtask
    task automatic cmd_wr(input int b, input int c, input logic [DW-1:0] d);
        step(C_WR, b, c, d, 1'b1);
    endtask

    task automatic apply_reset();
        @(negedge u_clk);
        u_rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge u_clk);
        @(negedge u_clk);
        u_rst_n = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge u_clk);
        u_rst_n = 1'b0;
        model_reset();
        #2;
        total++; if (dram_rd_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", dram_rd_valid); end
        total++; if (dram_rd_data !== '0) begin bad++; $display("FAIL reset_data got=%h exp=00", dram_rd_data); end
        total++; if (err_status !== 6'd0) begin bad++; $display("FAIL reset_err got=%b exp=000000", err_status); end
        total++; if (err_pulse !== 1'b0) begin bad++; $display("FAIL reset_pulse got=%b exp=0", err_pulse); end
        repeat (2) @(posedge u_clk);
        @(negedge u_clk);
        u_rst_n = 1'b1;
        cmd_nop();
        total++; if (err_status !== 6'd0 || dram_rd_valid !== 1'b0) begin
            bad++; $display("FAIL reset_idle err=%b vld=%b exp err=000000 vld=0", err_status, dram_rd_valid);
        end
    endtask

    task automatic test_basic();
        apply_reset();
        cmd_act(2, 5);
        cmd_nop();
        cmd_wr(2, 3, 8'hA5);
        cmd_rd(2, 3);
        total++; if (dram_rd_valid !== 1'b0) begin bad++; $display("FAIL basic_early got=%b exp=0", dram_rd_valid); end
        cmd_nop();
        total++; if (dram_rd_valid !== 1'b1 || dram_rd_data !== 8'hA5) begin
            bad++; $display("FAIL basic_read vld=%b data=%h exp vld=1 data=a5", dram_rd_valid, dram_rd_data);
        end
        cmd_nop();
        total++; if (dram_rd_valid !== 1'b0) begin bad++; $display("FAIL basic_oneshot got=%b exp=0", dram_rd_valid); end
        total++; if (err_status !== 6'd0) begin bad++; $display("FAIL basic_err got=%b exp=000000", err_status); end
    endtask

    task automatic test_row_closed();
        apply_reset();
        cmd_rd(1, 0);
        total++; if (err_status !== 6'b001000 || err_pulse !== 1'b1) begin
            bad++; $display("FAIL closed_err err=%b pulse=%b exp err=001000 pulse=1", err_status, err_pulse);
        end
        cmd_nop();
        total++; if (err_pulse !== 1'b0 || dram_rd_valid !== 1'b0) begin
            bad++; $display("FAIL closed_pulse pulse=%b vld=%b exp 0 0", err_pulse, dram_rd_valid);
        end
        cmd_nop();
        total++; if (dram_rd_valid !== 1'b0 || err_status !== 6'b001000) begin
            bad++; $display("FAIL closed_drop vld=%b err=%b exp vld=0 err=001000", dram_rd_valid, err_status);
        end
    endtask

    task automatic test_act_open();
        apply_reset();
        cmd_act(0, 1);
        cmd_nop();
        cmd_wr(0, 0, 8'h11);
        cmd_act(0, 2);
        total++; if (err_status !== 6'b000010 || err_pulse !== 1'b1) begin
            bad++; $display("FAIL actopen_err err=%b pulse=%b exp err=000010 pulse=1", err_status, err_pulse);
        end
        cmd_nop();
        cmd_nop();
        cmd_wr(0, 0, 8'h22);
        cmd_rd(0, 0);
        cmd_nop();
        total++; if (dram_rd_valid !== 1'b1 || dram_rd_data !== 8'h22) begin
            bad++; $display("FAIL actopen_row2 vld=%b data=%h exp vld=1 data=22", dram_rd_valid, dram_rd_data);
        end
        cmd_pre(0);
        cmd_nop();
        cmd_act(0, 1);
        cmd_nop();
        cmd_rd(0, 0);
        cmd_nop();
        total++; if (dram_rd_valid !== 1'b1 || dram_rd_data !== 8'h11) begin
            bad++; $display("FAIL actopen_row1 vld=%b data=%h exp vld=1 data=11", dram_rd_valid, dram_rd_data);
        end
        total++; if (err_status !== 6'b000010) begin bad++; $display("FAIL actopen_sticky got=%b exp=000010", err_status); end
    endtask

    task automatic test_trcd();
        apply_reset();
        cmd_act(3, 7);
        cmd_nop();
        cmd_wr(3, 1, 8'h5A);
        cmd_pre(3);
        cmd_nop();
        cmd_act(3, 7);
        total++; if (err_status !== 6'd0) begin bad++; $display("FAIL trcd_rp_ok got=%b exp=000000", err_status); end
        cmd_rd(3, 1);
        total++; if (err_status !== 6'b000100) begin bad++; $display("FAIL trcd_err got=%b exp=000100", err_status); end
        cmd_nop();
        total++; if (dram_rd_valid !== 1'b1 || dram_rd_data !== 8'h5A) begin
            bad++; $display("FAIL trcd_data vld=%b data=%h exp vld=1 data=5a", dram_rd_valid, dram_rd_data);
        end
    endtask

    task automatic test_refresh();
        apply_reset();
        cmd_act(4, 9);
        cmd_nop();
        cmd_wr(4, 2, 8'h3C);
        cmd_ref();
        total++; if (err_status !== 6'b010000) begin bad++; $display("FAIL ref_open got=%b exp=010000", err_status); end
        cmd_rd(4, 2);
        total++; if (err_status !== 6'b010100 || err_pulse !== 1'b1) begin
            bad++; $display("FAIL ref_window err=%b pulse=%b exp err=010100 pulse=1", err_status, err_pulse);
        end
        cmd_nop();
        total++; if (dram_rd_valid !== 1'b0) begin bad++; $display("FAIL ref_dropped got=%b exp=0", dram_rd_valid); end
        cmd_rd(4, 2);
        total++; if (err_pulse !== 1'b0 || err_status !== 6'b010100) begin
            bad++; $display("FAIL ref_after pulse=%b err=%b exp pulse=0 err=010100", err_pulse, err_status);
        end
        cmd_nop();
        total++; if (dram_rd_valid !== 1'b1 || dram_rd_data !== 8'h3C) begin
            bad++; $display("FAIL ref_read vld=%b data=%h exp vld=1 data=3c", dram_rd_valid, dram_rd_data);
        end
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] d [4];
        apply_reset();
        cmd_act(6, 17);
        cmd_nop();
        for (int c = 0; c < 4; c++) begin
            d[c] = DW'($urandom);
            cmd_wr(6, c, d[c]);
        end
        for (int k = 0; k <= 4; k++) begin
            if (k < 4) cmd_rd(6, k);
            else       cmd_nop();
            if (k >= 1) begin
                total++;
                if (dram_rd_valid !== 1'b1 || dram_rd_data !== d[k-1]) begin
                    bad++; $display("FAIL b2b_word%0d vld=%b data=%h exp vld=1 data=%h", k - 1, dram_rd_valid, dram_rd_data, d[k-1]);
                end
            end
        end
    endtask

    task automatic test_watchdog();
        apply_reset();
`ifdef DRAM_MODEL_REFRESH_CHECK_EN
        repeat (CBR) cmd_nop();
        total++; if (err_status[5] !== 1'b0) begin bad++; $display("FAIL wd_early got=%b exp=0", err_status[5]); end
        cmd_nop();
        total++; if (err_status[5] !== 1'b1 || err_pulse !== 1'b1) begin
            bad++; $display("FAIL wd_expire err5=%b pulse=%b exp 1 1", err_status[5], err_pulse);
        end
        cmd_nop();
        total++; if (err_pulse !== 1'b0) begin bad++; $display("FAIL wd_once got=%b exp=0", err_pulse); end
`else
        repeat (CBR + 5) cmd_nop();
        total++; if (err_status !== 6'd0) begin bad++; $display("FAIL wd_absent got=%b exp=000000", err_status); end
`endif
    endtask

    task automatic test_reset_midburst();
        apply_reset();
        cmd_act(5, 3);
        cmd_nop();
        cmd_wr(5, 4, 8'h77);
        cmd_rd(5, 4);
        cmd_rd(5, 4);
        total++; if (dram_rd_valid !== 1'b1) begin bad++; $display("FAIL mid_burst got=%b exp=1", dram_rd_valid); end
        #2;
        u_rst_n = 1'b0;
        model_reset();
        #1;
        total++; if (dram_rd_valid !== 1'b0 || dram_rd_data !== '0) begin
            bad++; $display("FAIL mid_flush vld=%b data=%h exp vld=0 data=00", dram_rd_valid, dram_rd_data);
        end
        repeat (2) @(posedge u_clk);
        @(negedge u_clk);
        u_rst_n = 1'b1;
        cmd_act(5, 3);
        total++; if (dram_rd_valid !== 1'b0) begin bad++; $display("FAIL mid_stale got=%b exp=0", dram_rd_valid); end
        cmd_nop();
        cmd_rd(5, 4);
        cmd_nop();
        total++; if (dram_rd_valid !== 1'b1 || dram_rd_data !== 8'h77) begin
            bad++; $display("FAIL mid_retain vld=%b data=%h exp vld=1 data=77", dram_rd_valid, dram_rd_data);
        end
    endtask

    task automatic test_random();
        int          r;
        logic [3:0]  code;
        apply_reset();
        for (int i = 0; i < 600; i++) begin
            if (i % 100 == 99) apply_reset();
            r = $urandom_range(0, 99);
            if      (r < 8)  code = C_NOP;
            else if (r < 30) code = C_RD;
            else if (r < 50) code = C_WR;
            else if (r < 65) code = C_ACT;
            else if (r < 80) code = C_PRE;
            else if (r < 85) code = C_REF;
            else if (r < 87) code = 4'b0000;
            else if (r < 89) code = 4'b0110;
            else if (r < 94) code = C_DES;
            else             code = C_NOP;
            step(code, $urandom_range(0, 3), $urandom_range(0, 7), DW'($urandom), $urandom_range(0, 9) != 0);
            total++; if (dram_rd_valid !== exp_vld) begin
                bad++; $display("FAIL rand_valid i=%0d got=%b exp=%b", i, dram_rd_valid, exp_vld);
            end
            if (exp_vld) begin
                total++; if (dram_rd_data !== exp_data) begin
                    bad++; $display("FAIL rand_data i=%0d got=%h exp=%h", i, dram_rd_data, exp_data);
                end
            end
            total++; if (err_status !== m_err) begin
                bad++; $display("FAIL rand_err i=%0d got=%b exp=%b", i, err_status, m_err);
            end
            total++; if (err_pulse !== m_pulse) begin
                bad++; $display("FAIL rand_pulse i=%0d got=%b exp=%b", i, err_pulse, m_pulse);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout sim_time=%0t limit=2000000", $time);
        $fatal(1, "timeout");
    end

    initial begin
        model_reset();
        test_reset();
        test_basic();
        test_row_closed();
        test_act_open();
        test_trcd();
        test_refresh();
        test_back_to_back();
        test_watchdog();
        test_reset_midburst();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dram_device_model.md
# dram_device_model

Cycle-accurate synthesizable responder for the controller's DRAM command interface. Decodes `cs_n/ras_n/cas_n/we_n` and tracks per-bank open rows and timing. Stores write data and returns read data after a fixed CAS latency. Flags protocol violations so the controller can be verified closed-loop in simulation and on FPGA.

## Interface
Parameters:
- `NUMBER_OF_COLUMNS`, 8: columns per row
- `NUMBER_OF_ROWS`, 128: rows per bank
- `NUMBER_OF_BANKS`, 8: banks
- `DRAM_DATA_WIDTH`, 8: data word width
- `CAS_LATENCY`, 2: READ-to-data cycles, legal range 1..4
- `T_RCD`, 1: minimum cycles from ACTIVATE to READ/WRITE on the same bank
- `T_RP`, 1: minimum cycles from PRECHARGE to ACTIVATE/REFRESH
- `T_RFC`, 2: cycles a REFRESH occupies
- `CYCLES_BETWEEN_REFRESH`, 1250: refresh deadline in cycles
- Derived widths: `COLUMN_WIDTH`, `ROW_WIDTH`, `BANK_ID_WIDTH` (each is $clog2 of its count); `DRAM_ADDR_WIDTH` is the max of the row and column widths.

Ports:
- `u_clk` in 1: the single clock
- `u_rst_n` in 1: asynchronous, active-low reset
- `dram_clk_en` in 1: when low, the command is ignored and the read pipeline holds
- `dram_cs_n`, `dram_ras_n`, `dram_cas_n`, `dram_we_n` in 1 each: command pins
- `dram_addr` in `DRAM_ADDR_WIDTH`: row (ACTIVATE) or column (READ/WRITE), taken from the LSBs
- `dram_bank_id` in `BANK_ID_WIDTH`: target bank
- `dram_wr_data` in `DRAM_DATA_WIDTH`: write data, sampled with WRITE
- `dram_rd_data` out `DRAM_DATA_WIDTH`: read data
- `dram_rd_valid` out 1: `dram_rd_data` is valid
- `err_status` out 6: sticky violation flags
- `err_pulse` out 1: one-cycle pulse on any new violation

## Operation
- Decode uses {cs_n, ras_n, cas_n, we_n}:
  - `1xxx` = DESELECT, `0111` = NOP
  - `0011` = ACTIVATE, `0010` = PRECHARGE
  - `0101` = READ, `0100` = WRITE
  - `0001` = REFRESH
  - Any other code is ILLEGAL. It sets err[0] and is otherwise treated as NOP.
- Per-bank state is an open flag, the active row and a timing down-counter.
- ACTIVATE: opens the bank and latches the row.
  - If the bank is already open: set err[1], replace the row.
  - If T_RP has not elapsed: set err[2], execute anyway.
- PRECHARGE: closes the addressed bank only and reloads its counter with T_RP. PRECHARGE of a closed bank is legal (NOP).
- READ/WRITE:
  - To a closed bank: set err[3] and drop the command (no array access, no `dram_rd_valid`).
  - Before T_RCD has elapsed: set err[2], execute anyway.
  - Array index is {bank, active_row, column}.
- REFRESH:
  - With any bank open: set err[4] and execute anyway.
  - Occupies T_RFC cycles. Any non-NOP command during that window sets err[2] and is dropped.
- Refresh watchdog: a counter reloads on every REFRESH. Reaching zero without one sets err[5] once per expiry, then the counter reloads.
- When `dram_clk_en` is low, all counters, the watchdog and the read pipeline freeze.

## Timing
- A command is sampled on the rising edge that ends cycle n.
- WRITE updates the array at that edge.
- READ: `dram_rd_data` and `dram_rd_valid` are asserted during cycle n+CAS_LATENCY for exactly one cycle. Back-to-back READs stream one word per cycle.
- WRITE in cycle n followed by READ of the same address in cycle n+1 returns the new data.
- `err_status` bits set at the edge ending the offending cycle. `err_pulse` is high during the following cycle. Bits clear only on reset.
- Reset values: `dram_rd_data` = 0, `dram_rd_valid` = 0, `err_status` = 0, `err_pulse` = 0, all banks closed, all counters zero (timing satisfied), watchdog = `CYCLES_BETWEEN_REFRESH`.
- Reset mid-operation flushes in-flight reads and does not alter array contents.
- The array itself has no reset.

## Configuration
- `DRAM_MODEL_REFRESH_CHECK_EN` defined: the watchdog and err[5] are present.
- Not defined: the watchdog logic is removed and err[5] is tied to 0. REFRESH, T_RFC and err[4] behave unchanged.

## Structure
- Package `dram_pkg` holds:
  - the command encoding enum (NOP, ACT, PRE, RD, WR, REF, ILLEGAL)
  - the err bit index constants (ILLEGAL_CMD = 0, ACT_OPEN = 1, TIMING = 2, ROW_CLOSED = 3, REF_OPEN = 4, REF_OVERDUE = 5)
- Sub-module `dram_bank_state`, instantiated once per bank via generate. It holds the open flag, the active row, and the T_RCD/T_RP counter with a "ready" output.

## Test plan
- ACTIVATE bank 2 row 5; WRITE col 3 data 0xA5; READ col 3 with CL = 2 -> `dram_rd_valid` and 0xA5 exactly 2 cycles after the READ, `err_status` = 0.
- READ bank 1 with no prior ACTIVATE -> err[3] set, `err_pulse` for one cycle, no `dram_rd_valid`.
- ACTIVATE bank 0 row 1, then ACTIVATE bank 0 row 2 -> err[1]; a subsequent READ uses row 2 data.
- With T_RCD = 2: ACTIVATE then READ next cycle -> err[2] set, and data is still returned.
- REFRESH while bank 4 is open -> err[4]. Any command during the T_RFC window -> err[2], command dropped.
- With the macro defined and `CYCLES_BETWEEN_REFRESH` = 20, no REFRESH for 21 cycles -> err[5] set. Assert `u_rst_n` low mid-burst -> valid drops immediately and the array is retained.
